// File: rtl/idecode_pipe.sv
// idecode_pipe: elastic RV32I decode stage.
// Decodes each accepted instruction combinationally and stores only the decoded
// record in a 2-entry FIFO whose head drives the execute-facing outputs.
module idecode_pipe #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_f3,
    output logic [6:0]       out_f7,
    output logic [XLEN-1:0]  out_imm,
    output logic [5:0]       out_fmt,
    output logic [5:0]       out_cls,
    output logic             out_illegal,
    output logic [CNT_W-1:0] dec_count
);

    // Format bit positions in the one-hot fmt vector {J,U,B,S,I,R}
    localparam int F_R = 0;
    localparam int F_I = 1;
    localparam int F_S = 2;
    localparam int F_B = 3;
    localparam int F_U = 4;
    localparam int F_J = 5;

    // Class bit positions in the one-hot cls vector {sys,jump,branch,store,load,alu}
    localparam int C_ALU    = 0;
    localparam int C_LOAD   = 1;
    localparam int C_STORE  = 2;
    localparam int C_BRANCH = 3;
    localparam int C_JUMP   = 4;
    localparam int C_SYS    = 5;

    // Buffer occupancy states
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_HALF  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [XLEN-1:0] imm;
        logic [5:0]      fmt;
        logic [5:0]      cls;
        logic            illegal;
    } rec_t;

    logic [5:0]      w_fmt;
    logic [5:0]      w_cls;
    logic            w_illegal;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    rec_t            w_rec;
    rec_t            w_head;
    rec_t            w_out;
    logic            w_push;
    logic            w_pop;
    logic [1:0]      w_state_next;

    logic [1:0]       r_state;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    rec_t             r_mem [2];

    // Opcode classification; every legal opcode ends in 2'b11, so a bad
    // instr[1:0] always falls into the illegal default.
    always_comb begin
        w_fmt     = '0;
        w_cls     = '0;
        w_illegal = 1'b0;
        case (in_instr[6:0])
            7'b0110011: begin w_fmt[F_R] = 1'b1; w_cls[C_ALU]    = 1'b1; end
            7'b0010011: begin w_fmt[F_I] = 1'b1; w_cls[C_ALU]    = 1'b1; end
            7'b0000011: begin w_fmt[F_I] = 1'b1; w_cls[C_LOAD]   = 1'b1; end
            7'b1100111: begin w_fmt[F_I] = 1'b1; w_cls[C_JUMP]   = 1'b1; end
            7'b0100011: begin w_fmt[F_S] = 1'b1; w_cls[C_STORE]  = 1'b1; end
            7'b1100011: begin w_fmt[F_B] = 1'b1; w_cls[C_BRANCH] = 1'b1; end
            7'b0110111,
            7'b0010111: begin w_fmt[F_U] = 1'b1; w_cls[C_ALU]    = 1'b1; end
            7'b1101111: begin w_fmt[F_J] = 1'b1; w_cls[C_JUMP]   = 1'b1; end
            7'b0001111,
            7'b1110011: begin w_fmt[F_I] = 1'b1; w_cls[C_SYS]    = 1'b1; end
            default:    w_illegal = 1'b1;
        endcase
    end

    // Immediate assembly per format; illegal and R records keep zero
    always_comb begin
        w_imm32 = '0;
        if (w_fmt[F_I])
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        else if (w_fmt[F_S])
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        else if (w_fmt[F_B])
            w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
        else if (w_fmt[F_U])
            w_imm32 = {in_instr[31:12], 12'b0};
        else if (w_fmt[F_J])
            w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
    end

    // Widen to XLEN by replicating the sign bit
    generate
        if (XLEN > 32) begin : g_imm_ext
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_imm_32
            assign w_imm = w_imm32[XLEN-1:0];
        end
    endgenerate

    // Field gating: absent fields read zero; illegal has fmt=0 so all gate off
    always_comb begin
        w_rec         = '0;
        w_rec.pc      = in_pc;
        w_rec.rd      = (w_fmt[F_R] | w_fmt[F_I] | w_fmt[F_U] | w_fmt[F_J]) ? in_instr[11:7] : 5'd0;
        w_rec.rs1     = (w_fmt[F_R] | w_fmt[F_I] | w_fmt[F_S] | w_fmt[F_B]) ? in_instr[19:15] : 5'd0;
        w_rec.f3      = (w_fmt[F_R] | w_fmt[F_I] | w_fmt[F_S] | w_fmt[F_B]) ? in_instr[14:12] : 3'd0;
        w_rec.rs2     = (w_fmt[F_R] | w_fmt[F_S] | w_fmt[F_B]) ? in_instr[24:20] : 5'd0;
        w_rec.f7      = w_fmt[F_R] ? in_instr[31:25] : 7'd0;
        w_rec.imm     = w_imm;
        w_rec.fmt     = w_fmt;
        w_rec.cls     = w_cls;
        w_rec.illegal = w_illegal;
    end

    // Handshake decode; ready and valid come purely from registered state
    assign in_ready  = (r_state != S_FULL);
    assign out_valid = (r_state != S_EMPTY);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready;

    // Occupancy next-state; flush overrides any push or pop
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push) w_state_next = S_HALF;
                S_HALF: begin
                    if (w_push && !w_pop)      w_state_next = S_FULL;
                    else if (!w_push && w_pop) w_state_next = S_EMPTY;
                end
                S_FULL:  if (w_pop) w_state_next = S_HALF;
                default: w_state_next = S_EMPTY;
            endcase
        end
    end

    // State, pointers and saturating consumed-record counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_EMPTY;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_next;
            if (flush) begin
                r_wr_ptr <= 1'b0;
                r_rd_ptr <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= ~r_wr_ptr;
                if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
                if (w_pop && (r_count != {CNT_W{1'b1}}))
                    r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Record storage; contents need no reset because outputs are gated by valid
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_rec;
    end

    // Head record, forced to zero while nothing is buffered
    assign w_head = r_mem[r_rd_ptr];
    always_comb begin
        w_out = '0;
        if (out_valid)
            w_out = w_head;
    end

    assign out_pc      = w_out.pc;
    assign out_rd      = w_out.rd;
    assign out_rs1     = w_out.rs1;
    assign out_rs2     = w_out.rs2;
    assign out_f3      = w_out.f3;
    assign out_f7      = w_out.f7;
    assign out_imm     = w_out.imm;
    assign out_fmt     = w_out.fmt;
    assign out_cls     = w_out.cls;
    assign out_illegal = w_out.illegal;
    assign dec_count   = r_count;

endmodule

// File: doc/idecode_pipe.md
# idecode_pipe

Parametrised, elastic RV32I decode stage. It replaces the single-register decoder with a valid/ready pipeline stage. Each accepted 32-bit instruction is fully decoded: register fields, sign-extended immediate, one-hot format, one-hot class and an illegal flag. The decoded record is held in a 2-entry buffer that absorbs back-pressure from execute. The stage sits between fetch (upstream) and the execute/ALU stage (downstream), and adds flush support and a saturating decoded-instruction counter.

## Interface
- XLEN, 32: immediate output width, 32 or 64; the sign bit instr[31] fills all upper bits.
- PC_W, 32: width of the PC carried alongside each instruction.
- CNT_W, 16: width of the decoded-instruction counter.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous; discards all buffered and incoming instructions.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage can accept an instruction; equals !FULL.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  head record valid.
- out_ready  in  1  execute takes the head record.
- out_pc  out  PC_W  PC of the head record.
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_f3  out  3  funct3.
- out_f7  out  7  funct7.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  6  one-hot format {J,U,B,S,I,R}, with R at bit 0.
- out_cls  out  6  one-hot class {sys,jump,branch,store,load,alu}, with alu at bit 0.
- out_illegal  out  1  unrecognised encoding.
- dec_count  out  CNT_W  number of records consumed downstream; saturating.

## Operation
- Decoding happens combinationally on in_instr. Only decoded records are stored; the raw instruction is not buffered.
- Opcode map:
  - 0110011: R, alu.
  - 0010011: I, alu.
  - 0000011: I, load.
  - 1100111: I, jump.
  - 0100011: S, store.
  - 1100011: B, branch.
  - 0110111 and 0010111: U, alu.
  - 1101111: J, jump.
  - 0001111 and 1110011: I, sys.
- Any other opcode, or instr[1:0] != 2'b11, is illegal. An illegal record has out_illegal=1, fmt=0, cls=0 and all fields 0. It is still passed downstream so execute can raise an exception.
- Field gating (fields absent in the format are forced to 0):
  - rd: zero for S and B.
  - rs1 and f3: zero for U and J.
  - rs2: nonzero only for R, S and B.
  - f7: nonzero only for R.
- Immediate assembly, then sign-extended from its top bit to XLEN:
  - R: 0.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Buffer FSM states:
  - EMPTY to HALF on push.
  - HALF to FULL on push without pop.
  - HALF to EMPTY on pop without push.
  - HALF stays HALF on simultaneous push and pop.
  - FULL to HALF on pop. There is no push in FULL because in_ready=0.
- Push = in_valid && in_ready && !flush. Pop = out_valid && out_ready.
- Records leave in strict FIFO order.
- flush has priority over everything. The next state is EMPTY. A push in the same cycle is discarded, and a pop in the same cycle is not counted.
- dec_count increments by 1 on each pop when flush is low. It saturates at all-ones and is cleared only by rst.

## Timing
- Reset values: in_ready=1, out_valid=0, all out_* fields=0, dec_count=0, state EMPTY.
- Reset mid-operation drops all buffered records immediately (asynchronous).
- Latency: a record pushed at edge N is presented on out_* after edge N, i.e. 1 cycle. There is no combinational path from in_* to out_*.
- Throughput is 1 record per cycle while out_ready=1.
- in_ready is a registered state decode. There is no combinational path from out_ready to in_ready, so a pop in FULL re-enables in_ready one cycle later.
- While out_valid=0, all out_* fields read 0.
- out_* fields remain stable while out_valid=1 and out_ready=0.

## Test plan
- Push 0xFFF10093 (addi x1,x2,-1) with out_ready=1 -> next cycle: out_valid=1, fmt=6'b000010, cls=6'b000001, rd=1, rs1=2, rs2=0, f3=0, out_imm=0xFFFFFFFF. Repeat with XLEN=64 -> out_imm=0xFFFFFFFFFFFFFFFF.
- Push 0xFE208EE3 (beq x1,x2,-4) -> fmt=6'b001000, cls=6'b000100, rd=0, rs1=1, rs2=2, out_imm=0xFFFFFFFC. Push 0x123452B7 (lui x5,0x12345) -> fmt=6'b010000, rd=5, rs1=0, out_imm=0x12345000.
- Push 0x00000000 -> out_illegal=1, fmt=0, cls=0, all fields 0. dec_count increments when it is popped.
- Hold out_ready=0 and offer A, B, C back-to-back -> A and B accepted, in_ready=0 after the second push, C held. Then raise out_ready -> outputs A, B, C in order on consecutive cycles; dec_count increases by 3.
- Fill to FULL, then pulse flush with in_valid=1 and out_ready=1 -> next cycle: out_valid=0, in_ready=1, dec_count unchanged, the offered instruction is not seen downstream.
- Preset CNT_W=4 and pop 20 records -> dec_count stops at 15. Assert rst while in HALF -> out_valid=0 and dec_count=0 immediately, before the next edge.
